// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the control-unit decoder:
// sequencer states, opcode field geometry and the HALT opcode value.
package instr_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } seq_state_e;

    localparam int unsigned      OPC_W       = 3;
    localparam logic [OPC_W-1:0] HALT_OP_DEF = 3'b111;

endpackage

// File: rtl/instr_fetch_sequencer_pc_counter.sv
// Program counter: synchronous reset to PC_RST, branch load, or +1 with
// natural wrap at 2^ADDR_W. Load has priority over increment.
module instr_fetch_sequencer_pc_counter #(
    parameter int unsigned       ADDR_W = 8,
    parameter logic [ADDR_W-1:0] PC_RST = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch/issue/execute sequencer: fetches words over req/ack, issues them to
// the control unit, applies branch redirects, stops on HALT or watchdog expiry.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       INSTR_W = 16,
    parameter logic [OPC_W-1:0]  HALT_OP = HALT_OP_DEF,
    parameter int unsigned       TIMEOUT = 16,
    parameter logic [ADDR_W-1:0] PC_RST  = '0
) (
    input  logic               clock,
    input  logic               Resetn,
    input  logic               Run,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] iin,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               fault
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    seq_state_e         state_q, state_d;
    logic [INSTR_W-1:0] iin_q, iin_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               fault_q, fault_d;
    logic               pc_load, pc_inc;
    logic               issue_halt;

    assign issue_halt = (iin_q[INSTR_W-1 -: OPC_W] == HALT_OP);

    always_comb begin
        state_d = state_q;
        iin_d   = iin_q;
        wd_d    = wd_q;
        fault_d = fault_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    iin_d   = mem_data;
                    pc_inc  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_halt) begin
                    state_d = S_HALT;
                end else begin
                    wd_d    = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // exec_done is checked first so a done on the last watchdog cycle wins
                if (exec_done) begin
                    pc_load = br_valid;
                    state_d = Run ? S_FETCH : S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            iin_q   <= '0;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iin_q   <= iin_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    instr_fetch_sequencer_pc_counter #(
        .ADDR_W (ADDR_W),
        .PC_RST (PC_RST)
    ) u_pc (
        .clk_i      (clock),
        .rst_ni     (Resetn),
        .load_i     (pc_load),
        .load_val_i (br_addr),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    assign mem_req    = (state_q == S_FETCH);
    assign mem_addr   = pc;
    assign iin        = iin_q;
    assign exec_start = (state_q == S_ISSUE) && !issue_halt;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);
    assign fault      = fault_q;

endmodule
